// File: rtl/tile_framebuffer_pkg.sv
// Shared constants for the maze tile framebuffer: grid geometry, RGB332 colours,
// SPI packet layout and FSM state encodings.
package tile_framebuffer_pkg;

   localparam int FB_GRID_W  = 64;
   localparam int FB_GRID_H  = 32;
   localparam int FB_TILE_W  = 10;
   localparam int FB_TILE_H  = 15;
   localparam int FB_COLOR_W = 8;

   // RGB332: rrr_ggg_bb
   localparam logic [7:0] RGB_BLACK = 8'h00;
   localparam logic [7:0] RGB_RED   = 8'hE0;
   localparam logic [7:0] RGB_GREEN = 8'h1C;
   localparam logic [7:0] RGB_BLUE  = 8'h03;
   localparam logic [7:0] RGB_WHITE = 8'hFF;

   localparam logic [7:0] FB_BG_COLOR  = RGB_BLACK;
   localparam logic [7:0] FB_OUT_COLOR = RGB_BLACK;

   // SPI packet {x, y, colour}
   localparam int PACKET_W = 24;
   localparam int PKT_X_LSB = 16;
   localparam int PKT_Y_LSB = 8;
   localparam int PKT_C_LSB = 0;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_CLEAR = 1'b1;

endpackage

// File: rtl/tile_framebuffer_if.sv
// Bus between the SPI receiver / VGA driver side (master) and the framebuffer (slave).
interface tile_framebuffer_if
   import tile_framebuffer_pkg::*;
#(
   parameter int COLOR_W = FB_COLOR_W
);
   logic               wr_valid;
   logic [7:0]         wr_x;
   logic [7:0]         wr_y;
   logic [COLOR_W-1:0] wr_color;
   logic               clr_req;
   logic [9:0]         pixel_x;
   logic [9:0]         pixel_y;
   logic [COLOR_W-1:0] pixel_color;
   logic               busy;
   logic               wr_drop;

   modport master (
      output wr_valid, wr_x, wr_y, wr_color, clr_req, pixel_x, pixel_y,
      input  pixel_color, busy, wr_drop
   );

   modport slave (
      input  wr_valid, wr_x, wr_y, wr_color, clr_req, pixel_x, pixel_y,
      output pixel_color, busy, wr_drop
   );
endinterface

// File: rtl/tile_framebuffer_tile_ram.sv
// Simple dual-port tile store: one write port, one registered read port.
// Read-before-write on an address collision; no reset so it maps onto block RAM.
module tile_ram
   import tile_framebuffer_pkg::*;
#(
   parameter int AW = 11,
   parameter int DW = FB_COLOR_W
) (
   input  logic          CLOCK_25,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);
   logic [DW-1:0] r_mem [0:(1<<AW)-1];

   always_ff @(posedge CLOCK_25) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      o_rdata <= r_mem[i_raddr];
   end
endmodule

// File: rtl/tile_framebuffer.sv
// Tile framebuffer: clear engine, tile write arbitration and a 2-stage
// pixel -> tile colour read pipeline in front of the VGA driver.
module tile_framebuffer
   import tile_framebuffer_pkg::*;
#(
   parameter int GRID_W  = FB_GRID_W,
   parameter int GRID_H  = FB_GRID_H,
   parameter int TILE_W  = FB_TILE_W,
   parameter int TILE_H  = FB_TILE_H,
   parameter int COLOR_W = FB_COLOR_W,
   parameter logic [COLOR_W-1:0] BG_COLOR  = FB_BG_COLOR,
   parameter logic [COLOR_W-1:0] OUT_COLOR = FB_OUT_COLOR
) (
   input  logic           CLOCK_25,
   input  logic           reset,
   tile_framebuffer_if.slave fb_bus
);
   localparam int XW = $clog2(GRID_W);
   localparam int YW = $clog2(GRID_H);
   localparam int AW = XW + YW;
   localparam logic [AW-1:0] LAST_ADDR = AW'(GRID_W * GRID_H - 1);

   logic [0:0]         r_state;
   logic [AW-1:0]      r_clr_addr;
   logic               r_wr_drop;
   logic [XW-1:0]      r_tx;
   logic [YW-1:0]      r_ty;
   logic [1:0]         r_busy_pipe;
   logic [1:0]         r_area_pipe;

   logic               w_busy;
   logic               w_wr_inrange;
   logic               w_wr_ok;
   logic               w_we;
   logic [AW-1:0]      w_waddr;
   logic [COLOR_W-1:0] w_wdata;
   logic [9:0]         w_tx;
   logic [9:0]         w_ty;
   logic               w_in_area;
   logic [COLOR_W-1:0] w_ram_q;

   assign w_busy       = (r_state == ST_CLEAR);
   assign w_wr_inrange = (int'(fb_bus.wr_x) < GRID_W) && (int'(fb_bus.wr_y) < GRID_H);
   // The clear always wins: a write is lost while clearing or when clr_req lands with it.
   assign w_wr_ok      = fb_bus.wr_valid && !w_busy && !fb_bus.clr_req && w_wr_inrange;

   assign w_we    = w_busy || w_wr_ok;
   assign w_waddr = w_busy ? r_clr_addr : {fb_bus.wr_y[YW-1:0], fb_bus.wr_x[XW-1:0]};
   assign w_wdata = w_busy ? BG_COLOR : fb_bus.wr_color;

   always_ff @(posedge CLOCK_25) begin
      if (reset) begin
         r_state    <= ST_CLEAR;
         r_clr_addr <= '0;
         r_wr_drop  <= 1'b0;
      end else begin
         r_wr_drop <= fb_bus.wr_valid && !w_wr_ok;
         case (r_state)
            ST_CLEAR: begin
               r_clr_addr <= r_clr_addr + 1'b1;
               if (r_clr_addr == LAST_ADDR) r_state <= ST_IDLE;
            end
            default: begin
               if (fb_bus.clr_req) begin
                  r_state    <= ST_CLEAR;
                  r_clr_addr <= '0;
               end
            end
         endcase
      end
   end

   // S1: pixel -> tile coordinates; divisors are constants so this folds to fixed logic.
   assign w_tx      = fb_bus.pixel_x / 10'(TILE_W);
   assign w_ty      = fb_bus.pixel_y / 10'(TILE_H);
   assign w_in_area = (int'(w_tx) < GRID_W) && (int'(w_ty) < GRID_H);

   always_ff @(posedge CLOCK_25) begin
      if (reset) begin
         r_tx        <= '0;
         r_ty        <= '0;
         r_busy_pipe <= 2'b11;
         r_area_pipe <= 2'b00;
      end else begin
         r_tx        <= w_tx[XW-1:0];
         r_ty        <= w_ty[YW-1:0];
         r_busy_pipe <= {r_busy_pipe[0], w_busy};
         r_area_pipe <= {r_area_pipe[0], w_in_area};
      end
   end

   // S2: registered RAM read, aligned with the [1] taps of the side pipes.
   tile_ram #(.AW(AW), .DW(COLOR_W)) u_ram (
      .CLOCK_25 (CLOCK_25),
      .i_we     (w_we),
      .i_waddr  (w_waddr),
      .i_wdata  (w_wdata),
      .i_raddr  ({r_ty, r_tx}),
      .o_rdata  (w_ram_q)
   );

   assign fb_bus.pixel_color = r_busy_pipe[1] ? BG_COLOR :
                               (!r_area_pipe[1] ? OUT_COLOR : w_ram_q);
   assign fb_bus.busy        = w_busy;
   assign fb_bus.wr_drop     = r_wr_drop;
endmodule

// File: tb/tb_tile_framebuffer.sv
// Directed bench for tile_framebuffer: reset clear, writes, drops, clear engine,
// read-before-write, reset mid-clear, and a random write phase against a tile model.
module tb_tile_framebuffer;
   logic CLOCK_25;
   logic reset;
   int   chk_cnt;
   int   pass_cnt;
   logic [7:0] sb [0:2047];

   tile_framebuffer_if #(.COLOR_W(8)) fb ();

   tile_framebuffer dut (
      .CLOCK_25 (CLOCK_25),
      .reset    (reset),
      .fb_bus   (fb)
   );

   initial CLOCK_25 = 1'b0;
   always #20 CLOCK_25 = ~CLOCK_25;

   task automatic tick();
      @(posedge CLOCK_25);
      #1;
   endtask

   task automatic do_write(input int x, input int y, input logic [7:0] c, output logic drop);
      fb.wr_valid = 1'b1;
      fb.wr_x     = 8'(x);
      fb.wr_y     = 8'(y);
      fb.wr_color = c;
      tick();
      drop        = fb.wr_drop;
      fb.wr_valid = 1'b0;
   endtask

   task automatic read_px(input int x, input int y, output logic [7:0] c);
      fb.pixel_x = 10'(x);
      fb.pixel_y = 10'(y);
      tick();
      tick();
      c = fb.pixel_color;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (fb.busy === 1'b1 && n < 3000) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      logic [7:0] c;
      int n;
      reset = 1'b1;
      tick();
      chk_cnt++; if (fb.busy !== 1'b1) $display("FAIL reset_busy: got %b expected 1", fb.busy); else pass_cnt++;
      chk_cnt++; if (fb.pixel_color !== 8'h00) $display("FAIL reset_color: got %h expected 00", fb.pixel_color); else pass_cnt++;
      chk_cnt++; if (fb.wr_drop !== 1'b0) $display("FAIL reset_drop: got %b expected 0", fb.wr_drop); else pass_cnt++;
      reset = 1'b0;
      wait_idle(n);
      chk_cnt++; if (n !== 2048) $display("FAIL reset_clear_len: got %0d expected 2048", n); else pass_cnt++;
      read_px(0, 0, c);
      chk_cnt++; if (c !== 8'h00) $display("FAIL reset_rd0: got %h expected 00", c); else pass_cnt++;
      read_px(327, 241, c);
      chk_cnt++; if (c !== 8'h00) $display("FAIL reset_rd1: got %h expected 00", c); else pass_cnt++;
      read_px(639, 479, c);
      chk_cnt++; if (c !== 8'h00) $display("FAIL reset_rd2: got %h expected 00", c); else pass_cnt++;
   endtask

   task automatic test_write_read();
      logic d;
      logic [7:0] c;
      do_write(3, 2, 8'hE0, d);
      chk_cnt++; if (d !== 1'b0) $display("FAIL wr_nodrop: got %b expected 0", d); else pass_cnt++;
      read_px(35, 30, c);
      chk_cnt++; if (c !== 8'hE0) $display("FAIL wr_tile32: got %h expected e0", c); else pass_cnt++;
      read_px(29, 30, c);
      chk_cnt++; if (c !== 8'h00) $display("FAIL wr_tile22: got %h expected 00", c); else pass_cnt++;
   endtask

   task automatic test_drop();
      logic d;
      logic [7:0] c;
      do_write(6, 6, 8'hAA, d);
      do_write(3, 1, 8'h55, d);
      do_write(64, 0, 8'hFF, d);
      chk_cnt++; if (d !== 1'b1) $display("FAIL drop_x64: got %b expected 1", d); else pass_cnt++;
      tick();
      chk_cnt++; if (fb.wr_drop !== 1'b0) $display("FAIL drop_pulse_len: got %b expected 0", fb.wr_drop); else pass_cnt++;
      do_write(0, 32, 8'hFF, d);
      chk_cnt++; if (d !== 1'b1) $display("FAIL drop_y32: got %b expected 1", d); else pass_cnt++;
      read_px(5, 5, c);
      chk_cnt++; if (c !== 8'h00) $display("FAIL drop_ram_unchanged: got %h expected 00", c); else pass_cnt++;
      read_px(65, 95, c);
      chk_cnt++; if (c !== 8'hAA) $display("FAIL drop_tile66: got %h expected aa", c); else pass_cnt++;
      // x=700 -> tile column 70, whose low bits alias tile (6,6)
      read_px(700, 95, c);
      chk_cnt++; if (c !== 8'h00) $display("FAIL out_x: got %h expected 00", c); else pass_cnt++;
      read_px(35, 500, c);
      chk_cnt++; if (c !== 8'h00) $display("FAIL out_y: got %h expected 00", c); else pass_cnt++;
      read_px(639, 479, c);
      chk_cnt++; if (c !== 8'h00) $display("FAIL corner: got %h expected 00", c); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic d0, d1, d2;
      logic [7:0] c;
      do_write(10, 10, 8'hA1, d0);
      do_write(11, 10, 8'hA2, d1);
      do_write(12, 10, 8'hA3, d2);
      chk_cnt++; if ({d0, d1, d2} !== 3'b000) $display("FAIL b2b_drop: got %b expected 000", {d0, d1, d2}); else pass_cnt++;
      read_px(100, 150, c);
      chk_cnt++; if (c !== 8'hA1) $display("FAIL b2b_0: got %h expected a1", c); else pass_cnt++;
      read_px(119, 164, c);
      chk_cnt++; if (c !== 8'hA2) $display("FAIL b2b_1: got %h expected a2", c); else pass_cnt++;
      read_px(125, 155, c);
      chk_cnt++; if (c !== 8'hA3) $display("FAIL b2b_2: got %h expected a3", c); else pass_cnt++;
   endtask

   task automatic test_rbw();
      logic d;
      do_write(5, 5, 8'h03, d);
      fb.pixel_x = 10'd55;
      fb.pixel_y = 10'd80;
      tick(); tick(); tick();
      chk_cnt++; if (fb.pixel_color !== 8'h03) $display("FAIL rbw_pre: got %h expected 03", fb.pixel_color); else pass_cnt++;
      fb.wr_valid = 1'b1; fb.wr_x = 8'd5; fb.wr_y = 8'd5; fb.wr_color = 8'h1C;
      tick();
      fb.wr_valid = 1'b0;
      chk_cnt++; if (fb.pixel_color !== 8'h03) $display("FAIL rbw_old: got %h expected 03", fb.pixel_color); else pass_cnt++;
      tick();
      chk_cnt++; if (fb.pixel_color !== 8'h1C) $display("FAIL rbw_new: got %h expected 1c", fb.pixel_color); else pass_cnt++;
   endtask

   task automatic test_clear();
      logic d, drop100;
      logic [7:0] c;
      int n, bad;
      do_write(1, 1, 8'h11, d);
      do_write(2, 3, 8'h22, d);
      fb.pixel_x = 10'd15;
      fb.pixel_y = 10'd20;
      tick(); tick(); tick();
      chk_cnt++; if (fb.pixel_color !== 8'h11) $display("FAIL clr_pre: got %h expected 11", fb.pixel_color); else pass_cnt++;
      chk_cnt++; if (fb.busy !== 1'b0) $display("FAIL clr_idle: got %b expected 0", fb.busy); else pass_cnt++;
      // Write coinciding with clr_req: the clear takes it
      fb.clr_req = 1'b1;
      fb.wr_valid = 1'b1; fb.wr_x = 8'd7; fb.wr_y = 8'd7; fb.wr_color = 8'hEE;
      tick();
      fb.clr_req = 1'b0;
      fb.wr_valid = 1'b0;
      chk_cnt++; if (fb.wr_drop !== 1'b1) $display("FAIL clr_coincide_drop: got %b expected 1", fb.wr_drop); else pass_cnt++;
      chk_cnt++; if (fb.busy !== 1'b1) $display("FAIL clr_busy_rise: got %b expected 1", fb.busy); else pass_cnt++;
      n = 0; bad = 0; drop100 = 1'b0;
      while (fb.busy === 1'b1 && n < 3000) begin
         if (n >= 2 && fb.pixel_color !== 8'h00) bad++;
         if (n == 100) begin
            fb.wr_valid = 1'b1; fb.wr_x = 8'd4; fb.wr_y = 8'd4; fb.wr_color = 8'h77;
         end
         if (n == 500) fb.clr_req = 1'b1;
         tick();
         if (n == 100) drop100 = fb.wr_drop;
         fb.wr_valid = 1'b0;
         fb.clr_req  = 1'b0;
         n++;
      end
      chk_cnt++; if (n !== 2048) $display("FAIL clr_len: got %0d expected 2048", n); else pass_cnt++;
      chk_cnt++; if (bad !== 0) $display("FAIL clr_bg_out: got %0d non-bg cycles expected 0", bad); else pass_cnt++;
      chk_cnt++; if (drop100 !== 1'b1) $display("FAIL clr_wr_drop: got %b expected 1", drop100); else pass_cnt++;
      read_px(15, 20, c);
      chk_cnt++; if (c !== 8'h00) $display("FAIL clr_t11: got %h expected 00", c); else pass_cnt++;
      read_px(25, 50, c);
      chk_cnt++; if (c !== 8'h00) $display("FAIL clr_t23: got %h expected 00", c); else pass_cnt++;
      read_px(45, 65, c);
      chk_cnt++; if (c !== 8'h00) $display("FAIL clr_t44: got %h expected 00", c); else pass_cnt++;
      read_px(35, 30, c);
      chk_cnt++; if (c !== 8'h00) $display("FAIL clr_t32: got %h expected 00", c); else pass_cnt++;
   endtask

   task automatic test_reset_mid_clear();
      int n;
      fb.clr_req = 1'b1;
      tick();
      fb.clr_req = 1'b0;
      repeat (1000) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk_cnt++; if (fb.busy !== 1'b1) $display("FAIL rst_mid_busy: got %b expected 1", fb.busy); else pass_cnt++;
      chk_cnt++; if (fb.pixel_color !== 8'h00) $display("FAIL rst_mid_color: got %h expected 00", fb.pixel_color); else pass_cnt++;
      wait_idle(n);
      chk_cnt++; if (n !== 2048) $display("FAIL rst_mid_len: got %0d expected 2048", n); else pass_cnt++;
   endtask

   task automatic test_random();
      logic v, exp_drop;
      int x, y;
      logic [7:0] c;
      for (int i = 0; i < 2048; i++) sb[i] = 8'h00;
      for (int i = 0; i < 10000; i++) begin
         v = 1'($urandom_range(0, 1));
         x = int'($urandom_range(0, 71));
         y = int'($urandom_range(0, 35));
         c = 8'($urandom);
         fb.wr_valid = v; fb.wr_x = 8'(x); fb.wr_y = 8'(y); fb.wr_color = c;
         tick();
         exp_drop = v && (x >= 64 || y >= 32);
         chk_cnt++; if (fb.wr_drop !== exp_drop) $display("FAIL rnd_drop[%0d]: got %b expected %b", i, fb.wr_drop, exp_drop); else pass_cnt++;
         if (v && !exp_drop) sb[y * 64 + x] = c;
      end
      fb.wr_valid = 1'b0;
      for (int ty = 0; ty < 32; ty++) begin
         for (int tx = 0; tx < 64; tx++) begin
            read_px(tx * 10 + tx % 10, ty * 15 + ty % 15, c);
            chk_cnt++; if (c !== sb[ty * 64 + tx]) $display("FAIL rnd_rd(%0d,%0d): got %h expected %h", tx, ty, c, sb[ty * 64 + tx]); else pass_cnt++;
         end
      end
   endtask

   initial begin
      chk_cnt  = 0;
      pass_cnt = 0;
      reset    = 1'b1;
      fb.wr_valid = 1'b0; fb.wr_x = '0; fb.wr_y = '0; fb.wr_color = '0;
      fb.clr_req  = 1'b0; fb.pixel_x = '0; fb.pixel_y = '0;
      test_reset();
      test_write_read();
      test_drop();
      test_back_to_back();
      test_rbw();
      test_clear();
      test_reset_mid_clear();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
